raster_timing_gen: RTL and testbench
====================================

Name: raster_timing_gen

Overview:
- Consumes the free-running 0..H_MAX line counter (`count`) and turns it into 2-D raster timing for the image-processing pipeline.
- Outputs: pixel coordinates x/y, data-enable, line/frame pulses and a linear pixel address.
- Each counter wrap is one line. Lines are counted into frames of V_TOTAL lines, of which the first V_ACTIVE are active.
- Also checks that the counter sequence is well-formed and flags corruption.

Parameters:
- H_MAX, 100, final counter value; line length is H_MAX+1 cycles.
- H_ACTIVE, 80, active pixels per line (count 0..H_ACTIVE-1); must be <= H_MAX.
- V_ACTIVE, 60, active lines per frame.
- V_TOTAL, 64, total lines per frame (active + vertical blank); must be > V_ACTIVE.
- AW, 16, pix_addr width; must satisfy 2^AW >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter
- reset  input  1  asynchronous, active-low
- enable  input  1  1 = run; 0 = return to IDLE on next edge
- count  input  8  line counter value, 0..H_MAX
- x  output  8  horizontal position (registered count)
- y  output  8  line index within frame, 0..V_TOTAL-1
- de  output  1  active pixel qualifier
- line_end  output  1  one-cycle pulse on the last cycle of each line
- frame_start  output  1  one-cycle pulse on pixel (0,0)
- frame_end  output  1  one-cycle pulse on the last cycle of line V_TOTAL-1
- pix_addr  output  AW  linear address of the current active pixel
- sync_err  output  1  sticky counter-sequence error flag

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0; state = IDLE.
  - The internal prev_count register is set to H_MAX, so a following count of 0 counts as a legal wrap.
- All outputs are registered. Latency is 1 cycle: `count` sampled at edge n is reflected on the outputs after edge n.
- prev_count updates every cycle, in every state.
- States:
  - IDLE: outputs 0 except sync_err (held). Go to WAIT_SOL when enable=1.
  - WAIT_SOL: wait for count==0.
    - On count==0 go to ACTIVE with y=0, pix_addr=0.
    - The first output cycle after entry has x=0, de=1, frame_start=1.
  - ACTIVE (y < V_ACTIVE):
    - x = count.
    - de = (count < H_ACTIVE).
    - pix_addr increments by 1 after every de cycle.
  - VBLANK (y >= V_ACTIVE): de=0; x still tracks count; pix_addr holds.
- Line advance:
  - When count==H_MAX: line_end=1.
  - y becomes y+1 at the next line start, wrapping V_TOTAL-1 → 0.
  - On the transition y = V_ACTIVE-1 → V_ACTIVE, state goes ACTIVE → VBLANK.
- Frame boundary:
  - When count==H_MAX and y==V_TOTAL-1: frame_end=1 in that cycle, coincident with line_end.
  - The next cycle (count==0) has y=0, frame_start=1, pix_addr=0, state ACTIVE.
- Sequence check, in ACTIVE/VBLANK only. A sample is legal iff either:
  - count == prev_count+1 and count <= H_MAX, or
  - prev_count == H_MAX and count == 0.
- On an illegal sample:
  - sync_err is set to 1 (sticky).
  - de, line_end and the frame pulses are forced 0 that cycle.
  - State goes to WAIT_SOL; y and pix_addr clear to 0.
  - Re-lock follows at the next count==0. A count==0 that is itself the illegal sample is not used for re-lock; re-lock waits for the next count==0.
- sync_err clears only on reset, or when enable=0 in IDLE.
- enable low mid-frame: next edge goes to IDLE; all outputs except sync_err go 0; y and pix_addr clear.
- Priority when events coincide: reset > enable=0 > sync error > frame wrap > line advance.
- Arithmetic:
  - y and x are 8-bit; pix_addr is AW bits.
  - pix_addr wraps modulo 2^AW. It cannot wrap under legal parameters; no saturation.
  - No multiplier: pix_addr is an incrementing counter.
- count bits above the value H_MAX are not masked; count > H_MAX is illegal and raises sync_err.

Decomposition:
- Shared package (timing_pkg):
  - state enum {IDLE, WAIT_SOL, ACTIVE, VBLANK};
  - default H_MAX, H_ACTIVE, V_ACTIVE, V_TOTAL constants, shared with the upstream counter so max values agree.
- One natural sub-module: seq_checker. It holds prev_count, evaluates the legality rule and produces a one-cycle err_pulse.
- The FSM, y counter and pix_addr stay in raster_timing_gen.

Test Plan:
- Reset then enable=1 with the counter driven 0..100 looping → frame_start at (x=0,y=0); 80 de cycles per line for lines 0..59; line_end every 101 cycles; frame_end at y=63, count=100; next cycle y=0, frame_start=1.
- Full frame → pix_addr runs 0..4799 across active pixels, holds 4799 through VBLANK, returns to 0 at frame_start; de count per frame = 4800.
- Glitch at y=10: inject count 37 after 35 → sync_err=1 next cycle; de=0; y and pix_addr=0; state WAIT_SOL; re-lock at next count=0 with frame_start=1; sync_err stays 1.
- Counter reset mid-line (count 50 → 0) → treated as illegal: sync_err=1; re-lock waits for the following wrap to 0.
- enable=0 at y=30, x=40 → all outputs 0 next cycle; re-enable → WAIT_SOL; lock at next count=0; then drop enable in IDLE → sync_err clears.
- Assert reset asynchronously mid-line (between edges) → all outputs 0 immediately, without waiting for a clock edge; after release with count=0, prev_count=H_MAX makes it legal, no sync_err.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared raster timing definitions.
// Holds the default line/frame geometry, which the upstream line counter also uses so that
// both blocks agree on H_MAX. Also holds the raster FSM state encoding.
package timing_pkg;

  localparam int unsigned H_MAX_DEF    = 100;
  localparam int unsigned H_ACTIVE_DEF = 80;
  localparam int unsigned V_ACTIVE_DEF = 60;
  localparam int unsigned V_TOTAL_DEF  = 64;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StWaitSol = 2'd1;
  localparam state_t StActive  = 2'd2;
  localparam state_t StVblank  = 2'd3;

  // True once the generator has locked onto a line start.
  function automatic logic is_locked(input state_t s);
    return (s == StActive) || (s == StVblank);
  endfunction

endpackage

// File: rtl/seq_checker.sv
// Line counter sequence checker.
// Remembers the previous counter sample and flags any sample that is not either the
// previous value plus one (within 0..H_MAX) or a wrap from H_MAX to 0.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset; prev_count returns to H_MAX
//   count     - line counter sample
//   check_en  - qualifies the check (only meaningful while locked)
//   err_pulse - combinational, high for the cycle in which an illegal sample is seen
module seq_checker
  import timing_pkg::*;
#(
  parameter int unsigned H_MAX = H_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  input  logic       check_en,
  output logic       err_pulse
);

  localparam logic [7:0] HMax = 8'(H_MAX);

  logic [7:0] prev_count_q;
  logic [8:0] prev_inc;
  logic       legal;

  // Reset to H_MAX so a first sample of 0 reads as a normal wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q <= HMax;
    end else begin
      prev_count_q <= count;
    end
  end

  // Nine bits so that prev_count = 255 cannot alias onto count = 0.
  assign prev_inc = {1'b0, prev_count_q} + 9'd1;

  always_comb begin
    legal = 1'b0;
    if (({1'b0, count} == prev_inc) && (count <= HMax)) begin
      legal = 1'b1;
    end else if ((prev_count_q == HMax) && (count == 8'd0)) begin
      legal = 1'b1;
    end
  end

  assign err_pulse = check_en & ~legal;

endmodule

// File: rtl/raster_timing_gen.sv
// Raster timing generator.
// Turns a free-running 0..H_MAX line counter into 2-D raster timing: pixel coordinates,
// data enable, line/frame pulses and a linear pixel address. All outputs are registered
// with one cycle of latency from the counter sample.
// Ports:
//   clk         - rising-edge clock shared with the line counter
//   reset       - asynchronous active-low reset
//   enable      - 1 = run, 0 = drop to idle on the next edge
//   count       - line counter value
//   x, y        - horizontal position / line index within the frame
//   de          - active pixel qualifier
//   line_end    - pulse on the last cycle of each line
//   frame_start - pulse on pixel (0,0)
//   frame_end   - pulse on the last cycle of the last line
//   pix_addr    - linear address of the current active pixel
//   sync_err    - sticky counter sequence error
module raster_timing_gen
  import timing_pkg::*;
#(
  parameter int unsigned H_MAX    = H_MAX_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    count,
  output logic [7:0]    x,
  output logic [7:0]    y,
  output logic          de,
  output logic          line_end,
  output logic          frame_start,
  output logic          frame_end,
  output logic [AW-1:0] pix_addr,
  output logic          sync_err
);

  localparam logic [7:0] HMax     = 8'(H_MAX);
  localparam logic [7:0] HAct     = 8'(H_ACTIVE);
  localparam logic [7:0] VAct     = 8'(V_ACTIVE);
  localparam logic [7:0] VTotLast = 8'(V_TOTAL - 1);

  state_t          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic            de_q, de_d;
  logic            line_end_q, line_end_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_end_q, frame_end_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            sync_err_q, sync_err_d;
  logic            check_en;
  logic            seq_err;

  assign check_en = enable & is_locked(state_q);

  seq_checker #(
    .H_MAX (H_MAX)
  ) u_seq_checker (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .check_en  (check_en),
    .err_pulse (seq_err)
  );

  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    addr_d        = addr_q;
    x_d           = 8'd0;
    de_d          = 1'b0;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    sync_err_d    = sync_err_q;

    if (!enable) begin
      state_d = StIdle;
      y_d     = 8'd0;
      addr_d  = '0;
      // Dropping enable while already idle is the software way to clear the error.
      if (state_q == StIdle) begin
        sync_err_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitSol;
          y_d     = 8'd0;
          addr_d  = '0;
        end
        StWaitSol: begin
          if (count == 8'd0) begin
            state_d       = StActive;
            y_d           = 8'd0;
            addr_d        = '0;
            x_d           = count;
            de_d          = (count < HAct);
            line_end_d    = (count == HMax);
            frame_start_d = 1'b1;
          end
        end
        StActive, StVblank: begin
          if (seq_err) begin
            // Abandon the frame and re-lock on the next genuine line start.
            sync_err_d = 1'b1;
            state_d    = StWaitSol;
            y_d        = 8'd0;
            addr_d     = '0;
          end else begin
            x_d         = count;
            line_end_d  = (count == HMax);
            frame_end_d = (count == HMax) && (y_q == VTotLast);
            if (count == 8'd0) begin
              if (y_q == VTotLast) begin
                state_d       = StActive;
                y_d           = 8'd0;
                addr_d        = '0;
                frame_start_d = 1'b1;
              end else begin
                y_d     = y_q + 8'd1;
                state_d = (y_d < VAct) ? StActive : StVblank;
              end
            end
            de_d = (state_d == StActive) && (count < HAct);
            // pix_addr names the current pixel, so it steps on entry to each de cycle
            // except the first pixel of the frame, which is address 0.
            if (de_d && !frame_start_d) begin
              addr_d = addr_q + AW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      de_q          <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      addr_q        <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      addr_q        <= addr_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign pix_addr    = addr_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
module tb_raster_timing_gen;

  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [7:0]    count;
  logic [7:0]    x;
  logic [7:0]    y;
  logic          de;
  logic          line_end;
  logic          frame_start;
  logic          frame_end;
  logic [AW-1:0] pix_addr;
  logic          sync_err;

  int errors = 0;
  int checks = 0;
  int cur_c  = 0;
  int cur_y  = 0;

  raster_timing_gen #(
    .H_MAX    (100),
    .H_ACTIVE (80),
    .V_ACTIVE (60),
    .V_TOTAL  (64),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .count       (count),
    .x           (x),
    .y           (y),
    .de          (de),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pix_addr    (pix_addr),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a counter sample, clock it in, and settle just after the edge.
  task automatic tick(input int c);
    count = 8'(c);
    @(posedge clk);
    #1;
  endtask

  // Advance the legal counter stream to line ty, count tc (no checking).
  task automatic run_to(input int ty, input int tc);
    while (!(cur_y == ty && cur_c == tc)) begin
      if (cur_c == 100) begin
        cur_c = 0;
        cur_y = (cur_y + 1) % 64;
      end else begin
        cur_c = cur_c + 1;
      end
      tick(cur_c);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    enable = 1'b0;
    count  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({x, y, de, line_end, frame_start, frame_end, pix_addr, sync_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d de=%b le=%b fs=%b fe=%b addr=%0d err=%b exp all 0",
               x, y, de, line_end, frame_start, frame_end, pix_addr, sync_err);
    end
    #2 reset = 1'b1;
    tick(0);
    checks++;
    if ({x, y, de, frame_start, sync_err} !== '0) begin
      errors++;
      $display("FAIL idle_outputs got x=%0d y=%0d de=%b fs=%b err=%b exp all 0",
               x, y, de, frame_start, sync_err);
    end
  endtask

  task automatic test_full_frame;
    logic [19:0] exp_v;
    logic [19:0] got_v;
    int          de_cnt;
    int          le_cnt;
    int          fe_cnt;
    int          exp_addr;
    int          bad_cycles;
    int          bad_addr;
    enable = 1'b1;
    tick(50);  // IDLE -> WAIT_SOL
    for (int c = 51; c <= 100; c++) tick(c);
    checks++;
    if (de !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL wait_sol_quiet got de=%b fs=%b exp 0 0", de, frame_start);
    end
    tick(0);
    checks++;
    if ({x, y, de, frame_start, pix_addr} !== {8'd0, 8'd0, 1'b1, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL lock_first_pixel got x=%0d y=%0d de=%b fs=%b addr=%0d exp 0 0 1 1 0",
               x, y, de, frame_start, pix_addr);
    end
    de_cnt = 1;
    le_cnt = 0;
    fe_cnt = 0;
    exp_addr = 1;
    bad_cycles = 0;
    bad_addr = 0;
    for (int l = 0; l < 64; l++) begin
      for (int c = 0; c <= 100; c++) begin
        if (l == 0 && c == 0) continue;
        tick(c);
        exp_v = {8'(c), 8'(l), (l < 60 && c < 80), (c == 100), 1'b0, (l == 63 && c == 100)};
        got_v = {x, y, de, line_end, frame_start, frame_end};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          bad_cycles++;
          if (bad_cycles <= 5)
            $display("FAIL frame_timing line=%0d count=%0d got=%h exp=%h", l, c, got_v, exp_v);
        end
        if (de) begin
          checks++;
          if (pix_addr !== 16'(exp_addr)) begin
            errors++;
            bad_addr++;
            if (bad_addr <= 5)
              $display("FAIL pix_addr line=%0d count=%0d got=%0d exp=%0d", l, c, pix_addr, exp_addr);
          end
          exp_addr++;
          de_cnt++;
        end
        le_cnt += int'(line_end);
        fe_cnt += int'(frame_end);
        if (l == 59 && c == 79) begin
          checks++;
          if (pix_addr !== 16'd4799) begin
            errors++;
            $display("FAIL last_pixel_addr got=%0d exp=4799", pix_addr);
          end
        end
        if (l == 63 && c == 100) begin
          checks++;
          if (pix_addr !== 16'd4799 || de !== 1'b0) begin
            errors++;
            $display("FAIL vblank_hold got addr=%0d de=%b exp 4799 0", pix_addr, de);
          end
        end
      end
    end
    checks++;
    if (de_cnt != 4800) begin
      errors++;
      $display("FAIL de_per_frame got=%0d exp=4800", de_cnt);
    end
    checks++;
    if (le_cnt != 64 || fe_cnt != 1) begin
      errors++;
      $display("FAIL pulse_counts got line_end=%0d frame_end=%0d exp 64 1", le_cnt, fe_cnt);
    end
    tick(0);
    checks++;
    if ({y, de, frame_start, frame_end, pix_addr} !== {8'd0, 1'b1, 1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL frame_wrap got y=%0d de=%b fs=%b fe=%b addr=%0d exp 0 1 1 0 0",
               y, de, frame_start, frame_end, pix_addr);
    end
    cur_c = 0;
    cur_y = 0;
  endtask

  task automatic test_glitch;
    logic quiet;
    run_to(10, 35);
    tick(37);
    checks++;
    if ({sync_err, de, y, pix_addr, line_end, frame_start} !== {1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL glitch_detect got err=%b de=%b y=%0d addr=%0d le=%b fs=%b exp 1 0 0 0 0 0",
               sync_err, de, y, pix_addr, line_end, frame_start);
    end
    quiet = 1'b1;
    for (int c = 38; c <= 100; c++) begin
      tick(c);
      if (de || frame_start || line_end || !sync_err) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL glitch_wait_sol got activity/err-clear while unlocked exp quiet");
    end
    tick(0);
    checks++;
    if ({frame_start, de, y, sync_err} !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL glitch_relock got fs=%b de=%b y=%0d err=%b exp 1 1 0 1",
               frame_start, de, y, sync_err);
    end
    cur_c = 0;
    cur_y = 0;
  endtask

  task automatic test_enable_drop;
    run_to(30, 40);
    checks++;
    if ({x, y, de, pix_addr} !== {8'd40, 8'd30, 1'b1, 16'd2440}) begin
      errors++;
      $display("FAIL pre_drop got x=%0d y=%0d de=%b addr=%0d exp 40 30 1 2440", x, y, de, pix_addr);
    end
    enable = 1'b0;
    tick(41);
    checks++;
    if ({x, y, de, line_end, frame_start, frame_end, pix_addr, sync_err} !==
        {8'd0, 8'd0, 4'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL enable_drop got x=%0d y=%0d de=%b addr=%0d err=%b exp 0 0 0 0 1",
               x, y, de, pix_addr, sync_err);
    end
    enable = 1'b1;
    tick(42);
    for (int c = 43; c <= 100; c++) tick(c);
    checks++;
    if ({x, de, frame_start} !== '0) begin
      errors++;
      $display("FAIL reenable_wait got x=%0d de=%b fs=%b exp 0 0 0", x, de, frame_start);
    end
    tick(0);
    checks++;
    if ({frame_start, de, y} !== {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reenable_lock got fs=%b de=%b y=%0d exp 1 1 0", frame_start, de, y);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (sync_err !== 1'b1 || de !== 1'b0) begin
      errors++;
      $display("FAIL err_held_leaving got err=%b de=%b exp 1 0", sync_err, de);
    end
    tick(2);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_idle got=%b exp=0", sync_err);
    end
  endtask

  task automatic test_counter_reset;
    enable = 1'b1;
    tick(3);
    for (int c = 4; c <= 100; c++) tick(c);
    tick(0);
    checks++;
    if (frame_start !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL cr_lock got fs=%b err=%b exp 1 0", frame_start, sync_err);
    end
    cur_c = 0;
    cur_y = 0;
    run_to(1, 50);
    checks++;
    if (y !== 8'd1 || x !== 8'd50) begin
      errors++;
      $display("FAIL cr_position got y=%0d x=%0d exp 1 50", y, x);
    end
    tick(0);
    checks++;
    if ({sync_err, de, y, frame_start} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL cr_detect got err=%b de=%b y=%0d fs=%b exp 1 0 0 0", sync_err, de, y, frame_start);
    end
    tick(1);
    checks++;
    if (frame_start !== 1'b0 || de !== 1'b0) begin
      errors++;
      $display("FAIL cr_no_early_lock got fs=%b de=%b exp 0 0", frame_start, de);
    end
    for (int c = 2; c <= 100; c++) tick(c);
    tick(0);
    checks++;
    if ({frame_start, de, sync_err} !== 3'b111) begin
      errors++;
      $display("FAIL cr_relock got fs=%b de=%b err=%b exp 1 1 1", frame_start, de, sync_err);
    end
    cur_c = 0;
    cur_y = 0;
  endtask

  task automatic test_async_reset;
    run_to(0, 20);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({x, y, de, line_end, frame_start, frame_end, pix_addr, sync_err} !== '0) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d de=%b addr=%0d err=%b exp all 0",
               x, y, de, pix_addr, sync_err);
    end
    enable = 1'b0;
    tick(0);
    #2 reset = 1'b1;
    enable = 1'b1;
    tick(100);
    tick(0);
    checks++;
    if ({frame_start, sync_err} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_lock got fs=%b err=%b exp 1 0", frame_start, sync_err);
    end
    tick(1);
    checks++;
    if ({x, de, pix_addr, sync_err} !== {8'd1, 1'b1, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_run got x=%0d de=%b addr=%0d err=%b exp 1 1 1 0",
               x, de, pix_addr, sync_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_glitch();
    test_enable_drop();
    test_counter_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
